chnl_pkt_arbiter: RTL and testbench
===================================

Name: chnl_pkt_arbiter

Overview:
- Packet-level arbiter between the three slave channels configured by ctrl_regs2 and the downstream formatter.
- Consumes each channel's enable, priority and packet-length fields, and selects one eligible channel per packet.
- Streams exactly one packet of words from the selected channel to a single valid/ready output, tagged with the channel id and first/last markers.

Parameters:
DW, 32, data word width
LENW, 3, width of slvN_len_i config field
PRIOW, 2, width of slvN_prio_i config field

Ports:
clk_i  input  1  clock, rising edge
rstn_i  input  1  asynchronous active-low reset
slvN_en_i (N=0..2)  input  1  channel enable from register block
slvN_prio_i (N=0..2)  input  PRIOW  channel priority; 0 = highest
slvN_len_i (N=0..2)  input  LENW  packet length code
slvN_req_i (N=0..2)  input  1  channel has a word available
slvN_data_i (N=0..2)  input  DW  channel head word
slvN_ack_o (N=0..2)  output  1  head word consumed this cycle
pkt_valid_o  output  1  output word valid
pkt_data_o  output  DW  output word
pkt_id_o  output  2  source channel id of current packet
pkt_first_o  output  1  first word of packet
pkt_last_o  output  1  last word of packet
pkt_ready_i  input  1  downstream accepts word
busy_o  output  1  packet in progress

Behaviour:
- Reset (async assert, sync deassert at the next edge): FSM=IDLE, beat counter=0, grant id=0, RR pointer last_grant=2 (ch0 wins first tie), busy_o=0. All slvN_ack_o, pkt_valid_o, pkt_first_o and pkt_last_o are 0; pkt_id_o=0; pkt_data_o=0.
- Eligible channel: slvN_en_i && slvN_req_i.
- Length decode, latched at grant: code 0->4 words, 1->8, 2->16, 3 to 7->32. Latched length is held in a 6-bit register.
- FSM states: IDLE and SEND.
- IDLE:
  - If no channel is eligible, stay in IDLE.
  - Otherwise pick the eligible channel with the numerically lowest prio.
  - Ties are broken round-robin, starting at (last_grant+1) mod 3.
  - Register the grant id and decoded length, clear the counter, go to SEND next cycle.
  - No output activity in IDLE.
- SEND:
  - pkt_valid_o = slv[gid]_req_i.
  - pkt_data_o = slv[gid]_data_i (combinational mux).
  - pkt_id_o = gid.
  - busy_o = 1.
  - Transfer occurs when pkt_valid_o && pkt_ready_i.
  - slv[gid]_ack_o = transfer; the other two acks are 0.
  - pkt_first_o = pkt_valid_o && (cnt==0).
  - pkt_last_o = pkt_valid_o && (cnt==len-1).
  - The counter increments on each transfer.
  - On the transfer with cnt==len-1: last_grant<=gid, go to IDLE. The minimum gap between packets is 1 IDLE cycle.
- Stalls:
  - req low or ready low holds the counter, the data path and the FSM.
  - There is no timeout.
  - Data-side outputs must remain combinationally consistent with the inputs.
- Config changes mid-packet (en, prio, len) do not affect the packet in progress. They take effect at the next arbitration.
- Deasserting slv[gid]_en_i mid-packet does not abort the packet; it completes.
- Reset mid-packet: the packet is abandoned, with no partial last indication. All state returns to reset values.
- pkt_id_o and the grant are stable for the whole SEND interval.
- At most one ack is high per cycle.

Test Plan:
- Single channel: ch1 en=1, prio=0, len=0, req constant, ready=1, 4 data words A0..A3 -> 1 IDLE cycle, then 4 consecutive beats with id=1, first on A0, last on A3; slv1_ack_o pulses 4 times; return to IDLE.
- Priority: all enabled and requesting, prio ch0=2, ch1=1, ch2=0, len=0 -> first packet id=2. With ch2 req held until its packet ends then dropped, the next packet is id=1.
- Round-robin: all prio=1, all requesting continuously, len=0 -> packet ids 0,1,2,0,1,2, with exactly 4 beats each and 1 IDLE gap between packets.
- Backpressure/stall: ch0 len=1 (8 words). Toggle ready every other cycle and drop req for 3 cycles after beat 4 -> exactly 8 transfers in order; no ack while ready or req is low; last on beat 8 only.
- Config change mid-packet: ch0 len=2 granted, then write len=0 and en=0 after beat 2 -> packet completes with 16 beats; ch0 is not granted again while en=0.
- Reset mid-packet: assert rstn_i after beat 3 of a 32-beat packet -> all outputs 0 immediately. After release, arbitration restarts with ch0 winning ties.

Source files
------------

// File: rtl/chnl_pkt_arbiter.sv
// Packet-level arbiter: picks one eligible slave channel per packet (lowest prio
// value, round-robin on ties) and streams a fixed-length packet to one valid/ready port.
//
// state | meaning
// IDLE  | no packet open; arbitrate among eligible channels
// SEND  | stream words from the granted channel until the latched length is sent
module chnl_pkt_arbiter #(
  parameter int DW    = 32,
  parameter int LENW  = 3,
  parameter int PRIOW = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             slv0_en_i,
  input  logic             slv1_en_i,
  input  logic             slv2_en_i,
  input  logic [PRIOW-1:0] slv0_prio_i,
  input  logic [PRIOW-1:0] slv1_prio_i,
  input  logic [PRIOW-1:0] slv2_prio_i,
  input  logic [LENW-1:0]  slv0_len_i,
  input  logic [LENW-1:0]  slv1_len_i,
  input  logic [LENW-1:0]  slv2_len_i,
  input  logic             slv0_req_i,
  input  logic             slv1_req_i,
  input  logic             slv2_req_i,
  input  logic [DW-1:0]    slv0_data_i,
  input  logic [DW-1:0]    slv1_data_i,
  input  logic [DW-1:0]    slv2_data_i,
  output logic             slv0_ack_o,
  output logic             slv1_ack_o,
  output logic             slv2_ack_o,
  output logic             pkt_valid_o,
  output logic [DW-1:0]    pkt_data_o,
  output logic [1:0]       pkt_id_o,
  output logic             pkt_first_o,
  output logic             pkt_last_o,
  input  logic             pkt_ready_i,
  output logic             busy_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gid;
  logic [1:0]       r_last_grant;
  logic [5:0]       r_len;
  logic [5:0]       r_cnt;

  logic [3:0]       w_req;
  logic [3:0]       w_elig;
  logic [PRIOW-1:0] w_prio [4];
  logic [LENW-1:0]  w_len  [4];
  logic [DW-1:0]    w_data [4];
  logic             w_found;
  logic [1:0]       w_win;
  logic [PRIOW-1:0] w_best;
  logic             w_valid;
  logic             w_xfer;
  logic             w_last_beat;

  // Slot 3 is a dead entry so a 2-bit index never selects an undriven element.
  assign w_req     = {1'b0, slv2_req_i, slv1_req_i, slv0_req_i};
  assign w_elig    = w_req & {1'b0, slv2_en_i, slv1_en_i, slv0_en_i};
  assign w_prio[0] = slv0_prio_i;
  assign w_prio[1] = slv1_prio_i;
  assign w_prio[2] = slv2_prio_i;
  assign w_prio[3] = '0;
  assign w_len[0]  = slv0_len_i;
  assign w_len[1]  = slv1_len_i;
  assign w_len[2]  = slv2_len_i;
  assign w_len[3]  = '0;
  assign w_data[0] = slv0_data_i;
  assign w_data[1] = slv1_data_i;
  assign w_data[2] = slv2_data_i;
  assign w_data[3] = '0;

  function automatic logic [1:0] rr_idx(input logic [1:0] last, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, last} + {1'b0, k} + 3'd1;
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [5:0] len_dec(input logic [LENW-1:0] code);
    logic [5:0] n;
    if (code == LENW'(0))      n = 6'd4;
    else if (code == LENW'(1)) n = 6'd8;
    else if (code == LENW'(2)) n = 6'd16;
    else                       n = 6'd32;
    return n;
  endfunction

  // Scan in round-robin order; strict '<' keeps the earliest channel on a tie.
  always_comb begin
    logic [1:0] idx;
    w_found = 1'b0;
    w_win   = 2'd0;
    w_best  = '0;
    idx     = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = rr_idx(r_last_grant, 2'(k));
      if (w_elig[idx] && (!w_found || (w_prio[idx] < w_best))) begin
        w_found = 1'b1;
        w_win   = idx;
        w_best  = w_prio[idx];
      end
    end
  end

  assign w_valid     = (r_state == ST_SEND) && w_req[r_gid];
  assign w_xfer      = w_valid && pkt_ready_i;
  assign w_last_beat = (r_cnt == (r_len - 6'd1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_gid        <= 2'd0;
      r_len        <= 6'd0;
      r_cnt        <= 6'd0;
      r_last_grant <= 2'd2;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE) begin
        if (w_found) begin
          r_gid <= w_win;
          r_len <= len_dec(w_len[w_win]);
          r_cnt <= 6'd0;
        end
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 6'd1;
        if (w_last_beat) r_last_grant <= r_gid;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_found) w_state_nxt = ST_SEND;
      ST_SEND: if (w_xfer && w_last_beat) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_valid_o = 1'b0;
    pkt_data_o  = '0;
    pkt_id_o    = 2'd0;
    pkt_first_o = 1'b0;
    pkt_last_o  = 1'b0;
    busy_o      = 1'b0;
    slv0_ack_o  = 1'b0;
    slv1_ack_o  = 1'b0;
    slv2_ack_o  = 1'b0;
    if (r_state == ST_SEND) begin
      pkt_valid_o = w_valid;
      pkt_data_o  = w_data[r_gid];
      pkt_id_o    = r_gid;
      pkt_first_o = w_valid && (r_cnt == 6'd0);
      pkt_last_o  = w_valid && w_last_beat;
      busy_o      = 1'b1;
      slv0_ack_o  = w_xfer && (r_gid == 2'd0);
      slv1_ack_o  = w_xfer && (r_gid == 2'd1);
      slv2_ack_o  = w_xfer && (r_gid == 2'd2);
    end
  end

endmodule

// File: tb/tb_chnl_pkt_arbiter.sv
// Scoreboard bench for chnl_pkt_arbiter: each test pushes the beats it expects,
// a negedge monitor compares every output word against the queue head.
module tb_chnl_pkt_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        first;
    logic        last;
  } beat_t;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [2:0]  en;
  logic [2:0]  req;
  logic [1:0]  prio [3];
  logic [2:0]  len  [3];
  logic [15:0] seq  [3];
  logic        ready;
  logic        slv0_ack_o, slv1_ack_o, slv2_ack_o;
  logic        pkt_valid_o, pkt_first_o, pkt_last_o, busy_o;
  logic [31:0] pkt_data_o;
  logic [1:0]  pkt_id_o;
  logic [31:0] data0, data1, data2;

  beat_t       q [$];
  int          gaps [$];
  int          ack_cnt [3];
  bit          pend [3];
  logic [15:0] m_seq [3];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk_word(input int ch, input logic [15:0] s);
    return {8'hA0 | 8'(ch), 8'h5A, s};
  endfunction

  assign data0 = mk_word(0, seq[0]);
  assign data1 = mk_word(1, seq[1]);
  assign data2 = mk_word(2, seq[2]);

  chnl_pkt_arbiter #(.DW(32), .LENW(3), .PRIOW(2)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .slv0_en_i   (en[0]),
    .slv1_en_i   (en[1]),
    .slv2_en_i   (en[2]),
    .slv0_prio_i (prio[0]),
    .slv1_prio_i (prio[1]),
    .slv2_prio_i (prio[2]),
    .slv0_len_i  (len[0]),
    .slv1_len_i  (len[1]),
    .slv2_len_i  (len[2]),
    .slv0_req_i  (req[0]),
    .slv1_req_i  (req[1]),
    .slv2_req_i  (req[2]),
    .slv0_data_i (data0),
    .slv1_data_i (data1),
    .slv2_data_i (data2),
    .slv0_ack_o  (slv0_ack_o),
    .slv1_ack_o  (slv1_ack_o),
    .slv2_ack_o  (slv2_ack_o),
    .pkt_valid_o (pkt_valid_o),
    .pkt_data_o  (pkt_data_o),
    .pkt_id_o    (pkt_id_o),
    .pkt_first_o (pkt_first_o),
    .pkt_last_o  (pkt_last_o),
    .pkt_ready_i (ready),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: compare at negedge, advance source heads just after the consuming edge.
  initial begin
    beat_t      b;
    logic [2:0] ack;
    logic [2:0] exp_ack;
    bit         prev_busy;
    int         idle_run;
    prev_busy = 1'b0;
    idle_run  = 0;
    for (int i = 0; i < 3; i++) begin
      seq[i]     = 16'h0;
      ack_cnt[i] = 0;
      pend[i]    = 1'b0;
    end
    forever begin
      @(negedge clk_i);
      if (rstn_i) begin
        ack = {slv2_ack_o, slv1_ack_o, slv0_ack_o};
        if (pkt_valid_o) begin
          if (q.size() == 0) begin
            chk("extra_beat", 64'(pkt_valid_o), 64'd0);
          end else begin
            b = q[0];
            chk("id", 64'(pkt_id_o), 64'(b.id));
            chk("data", 64'(pkt_data_o), 64'(b.data));
            chk("first", 64'(pkt_first_o), 64'(b.first));
            chk("last", 64'(pkt_last_o), 64'(b.last));
            chk("busy_send", 64'(busy_o), 64'd1);
            exp_ack = ready ? (3'b001 << b.id) : 3'b000;
            chk("ack", 64'(ack), 64'(exp_ack));
            if (ready) begin
              void'(q.pop_front());
              pend[b.id] = 1'b1;
              ack_cnt[b.id]++;
            end
          end
        end else begin
          chk("ack_noval", 64'(ack), 64'd0);
          chk("first_noval", 64'(pkt_first_o), 64'd0);
          chk("last_noval", 64'(pkt_last_o), 64'd0);
        end
        if (busy_o && !prev_busy) begin
          gaps.push_back(idle_run);
          idle_run = 0;
        end else if (!busy_o) begin
          idle_run++;
        end
        prev_busy = busy_o;
      end else begin
        prev_busy = 1'b0;
      end
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (pend[i]) begin
          seq[i]  = seq[i] + 16'd1;
          pend[i] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push_pkt(input int ch, input int nb, input int total);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.id    = 2'(ch);
      b.data  = mk_word(ch, m_seq[ch]);
      b.first = (i == 0);
      b.last  = (i == total - 1);
      q.push_back(b);
      m_seq[ch] = m_seq[ch] + 16'd1;
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(q.size()), 64'd0);
    q.delete();
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    step();
    step();
    rstn_i = 1'b1;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(pkt_valid_o), 64'd0);
    chk({tag, "_data"}, 64'(pkt_data_o), 64'd0);
    chk({tag, "_id"}, 64'(pkt_id_o), 64'd0);
    chk({tag, "_first"}, 64'(pkt_first_o), 64'd0);
    chk({tag, "_last"}, 64'(pkt_last_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_acks"}, 64'({slv2_ack_o, slv1_ack_o, slv0_ack_o}), 64'd0);
  endtask

  initial begin
    int base;
    int n;
    int drop;
    bit dropped;
    rstn_i = 1'b0;
    en     = 3'b001;
    req    = 3'b001;
    ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prio[i]  = 2'd0;
      len[i]   = 3'd0;
      m_seq[i] = 16'h0;
    end

    // Reset holds everything quiet even with a channel eligible.
    #3;
    check_all_zero("rst");
    step();
    step();
    check_all_zero("rst_hold");
    req = 3'b000;
    en  = 3'b000;
    rstn_i = 1'b1;
    step();
    step();
    chk("idle_busy", 64'(busy_o), 64'd0);

    // Single channel, 4-word packet.
    en[1] = 1'b1; prio[1] = 2'd0; len[1] = 3'd0;
    base = ack_cnt[1];
    push_pkt(1, 4, 4);
    req[1] = 1'b1;
    wait_drain("t1_drain", 50);
    req[1] = 1'b0;
    chk("t1_acks", 64'(ack_cnt[1] - base), 64'd4);
    step();
    chk("t1_idle", 64'(busy_o), 64'd0);

    // Priority: ch2 (prio 0) first, then ch1 (prio 1) once ch2 stops requesting.
    en = 3'b111; req = 3'b111;
    prio[0] = 2'd2; prio[1] = 2'd1; prio[2] = 2'd0;
    push_pkt(2, 4, 4);
    wait_drain("t2_drain_a", 50);
    req[2] = 1'b0;
    push_pkt(1, 4, 4);
    wait_drain("t2_drain_b", 50);
    req = 3'b000;
    step();

    // Round-robin from reset with equal priority.
    do_reset();
    for (int i = 0; i < 3; i++) prio[i] = 2'd1;
    en = 3'b111;
    gaps.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) push_pkt(c, 4, 4);
    req = 3'b111;
    wait_drain("t3_drain", 200);
    req = 3'b000;
    step();
    chk("rr_pkts", 64'(gaps.size()), 64'd6);
    for (int i = 1; i < gaps.size(); i++) chk("rr_gap", 64'(gaps[i]), 64'd1);

    // Backpressure and a 3-cycle request drop after beat 4 of an 8-word packet.
    en = 3'b001; prio[0] = 2'd0; len[0] = 3'd1;
    base = ack_cnt[0];
    push_pkt(0, 8, 8);
    req[0] = 1'b1;
    dropped = 1'b0; drop = 0; n = 0;
    while (q.size() != 0 && n < 300) begin
      step();
      n++;
      ready = ~ready;
      if (!dropped && (ack_cnt[0] - base == 4)) begin
        dropped = 1'b1;
        drop = 3;
      end
      req[0] = (drop == 0);
      if (drop > 0) drop--;
    end
    chk("t4_drain", 64'(q.size()), 64'd0);
    chk("t4_dropped", 64'(dropped), 64'd1);
    q.delete();
    ready = 1'b1;
    req[0] = 1'b0;
    chk("t4_acks", 64'(ack_cnt[0] - base), 64'd8);
    step();

    // Config change mid-packet does not shorten the 16-word packet.
    en = 3'b001; len[0] = 3'd2;
    base = ack_cnt[0];
    push_pkt(0, 16, 16);
    req[0] = 1'b1;
    n = 0;
    while ((ack_cnt[0] - base) < 2 && n < 50) begin
      step();
      n++;
    end
    len[0] = 3'd0;
    en[0]  = 1'b0;
    wait_drain("t5_drain", 100);
    chk("t5_acks", 64'(ack_cnt[0] - base), 64'd16);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t5_no_regrant", 64'(busy_o), 64'd0);
    end
    req[0] = 1'b0;

    // Reset after beat 3 of a 32-word packet, then ch0 wins the next tie.
    do_reset();
    en = 3'b111;
    for (int i = 0; i < 3; i++) begin
      prio[i] = 2'd1;
      len[i]  = 3'd3;
    end
    push_pkt(0, 3, 32);
    req = 3'b111;
    wait_drain("t6_drain_a", 50);
    rstn_i = 1'b0;
    #1;
    check_all_zero("t6_rst");
    for (int i = 0; i < 3; i++) len[i] = 3'd0;
    step();
    step();
    rstn_i = 1'b1;
    push_pkt(0, 4, 4);
    wait_drain("t6_drain_b", 50);
    req = 3'b000;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
